// File: rtl/adder_arb.sv
// adder_arb: two-requester arbiter and sequencer in front of a shared
// 5-bit + 5-bit -> 6-bit add, with a one-deep tagged result register and
// per-requester completion counters.
//
// Build option: ADDER_ARB_RR_EN
//   defined   -> round-robin between requesters, using a last-served pointer
//   undefined -> fixed priority, requester 0 always wins contention
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   reqN_valid/a/b/ready  requester N operand handshake (N = 0, 1)
//   res_valid/ready       result register handshake toward the consumer
//   res_sum, res_id       6-bit sum (carry in bit 5) and producing requester
//   cnt0, cnt1            8-bit wrapping count of accepted adds per requester
module adder_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [4:0] req0_a,
  input  logic [4:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [4:0] req1_a,
  input  logic [4:0] req1_b,
  output logic       req1_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res_sum,
  output logic       res_id,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
);

  typedef struct packed {
    logic       valid;
    logic [4:0] a;
    logic [4:0] b;
  } req_t;

  req_t [1:0] req;
  logic [1:0] gnt;
  logic [1:0] acc;
  logic       free;
  logic [5:0] sum_nxt;
  logic [7:0] cnt_q [2];

  assign req[0] = {req0_valid, req0_a, req0_b};
  assign req[1] = {req1_valid, req1_a, req1_b};

  // Slot can take a new result if empty or being drained this cycle.
  assign free = ~res_valid | res_ready;

`ifdef ADDER_ARB_RR_EN
  logic last;

  // On contention the requester not served last time wins.
  always_comb begin
    gnt[0] = req[0].valid & (~req[1].valid | last);
    gnt[1] = req[1].valid & (~req[0].valid | ~last);
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= 1'b1;
    else if (|acc) last <= acc[1];
  end
`else
  always_comb begin
    gnt[0] = req[0].valid;
    gnt[1] = req[1].valid & ~req[0].valid;
  end
`endif

  // rst_n gating keeps readies low for the whole time reset is asserted.
  assign req0_ready = gnt[0] & free & rst_n;
  assign req1_ready = gnt[1] & free & rst_n;
  assign acc        = {req1_valid & req1_ready, req0_valid & req0_ready};

  // Grants are one-hot, so select the accepted requester's operands.
  assign sum_nxt = acc[1] ? ({1'b0, req[1].a} + {1'b0, req[1].b})
                          : ({1'b0, req[0].a} + {1'b0, req[0].b});

  // Accept overwrites even when the old result is drained in the same cycle,
  // so back-to-back adds stream with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= 1'b0;
    end else if (|acc) begin
      res_valid <= 1'b1;
      res_sum   <= sum_nxt;
      res_id    <= acc[1];
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt_q[i] <= '0;
      else if (acc[i]) cnt_q[i] <= cnt_q[i] + 8'd1;
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];

endmodule

// File: tb/tb_adder_arb.sv
module tb_adder_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [4:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       res_valid, res_ready, res_id;
  logic [5:0] res_sum;
  logic [7:0] cnt0, cnt1;

  adder_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       m_valid, m_last, m_id;
  logic [5:0] m_sum;
  logic [7:0] m_cnt0, m_cnt1;

  typedef struct packed { logic [5:0] sum; logic id; } res_t;
  res_t sb[$];

  typedef struct {
    logic v0; logic [4:0] a0, b0;
    logic v1; logic [4:0] a1, b1;
    logic [5:0] sum; logic id;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_last = 1'b1; m_id = 1'b0; m_sum = '0;
    m_cnt0 = '0; m_cnt1 = '0;
    sb.delete();
  endtask

  // One clock: predict and check readies, apply the edge to the model,
  // then check all outputs just after the edge. Enters and leaves at negedge.
  task automatic cyc();
    logic g0, g1, fr, r0, r1;
    #1;
`ifdef ADDER_ARB_RR_EN
    g0 = req0_valid & (~req1_valid | m_last);
    g1 = req1_valid & (~req0_valid | ~m_last);
`else
    g0 = req0_valid;
    g1 = req1_valid & ~req0_valid;
`endif
    fr = ~m_valid | res_ready;
    r0 = g0 & fr;
    r1 = g1 & fr;
    chk("req0_ready", req0_ready, r0);
    chk("req1_ready", req1_ready, r1);
    @(posedge clk);
    if (m_valid && res_ready) begin
      void'(sb.pop_front());
      m_valid = 1'b0;
    end
    if (r0 || r1) begin
      m_sum   = r1 ? ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
      m_id    = r1;
      m_valid = 1'b1;
      m_last  = r1;
      sb.push_back({m_sum, m_id});
      if (r1) m_cnt1 = m_cnt1 + 8'd1;
      else    m_cnt0 = m_cnt0 + 8'd1;
    end
    #1;
    chk("res_valid", res_valid, m_valid);
    chk("res_sum", res_sum, m_sum);
    chk("res_id", res_id, m_id);
    chk("cnt0", cnt0, m_cnt0);
    chk("cnt1", cnt1, m_cnt1);
    if (m_valid && sb.size() > 0) begin
      chk("sb_sum", res_sum, sb[0].sum);
      chk("sb_id", res_id, sb[0].id);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [4:0] b0,
                       input logic v1, input logic [4:0] a1, input logic [4:0] b1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
  endtask

  logic exp_ids [4];
  logic [7:0] exp_c0, exp_c1;

  initial begin
    tbl[0] = '{1'b1, 5'd31, 5'd31, 1'b0, 5'd0,  5'd0,  6'd62, 1'b0};
    tbl[1] = '{1'b0, 5'd0,  5'd0,  1'b1, 5'd0,  5'd0,  6'd0,  1'b1};
    tbl[2] = '{1'b1, 5'd1,  5'd30, 1'b0, 5'd5,  5'd5,  6'd31, 1'b0};
    tbl[3] = '{1'b0, 5'd9,  5'd9,  1'b1, 5'd16, 5'd16, 6'd32, 1'b1};
    tbl[4] = '{1'b1, 5'd17, 5'd15, 1'b0, 5'd0,  5'd0,  6'd32, 1'b0};
    tbl[5] = '{1'b0, 5'd0,  5'd0,  1'b1, 5'd31, 5'd1,  6'd32, 1'b1};
`ifdef ADDER_ARB_RR_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1}; exp_c0 = 8'd2; exp_c1 = 8'd2;
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0}; exp_c0 = 8'd4; exp_c1 = 8'd0;
`endif

    rst_n = 1'b0; res_ready = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    model_reset();
    #2;
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_id", res_id, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-requester vectors, one add per cycle
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1);
      cyc();
      chk("tbl_sum", res_sum, tbl[i].sum);
      chk("tbl_id", res_id, tbl[i].id);
    end
    chk("tbl_cnt0", cnt0, 3);
    chk("tbl_cnt1", cnt1, 3);

    // Reset mid-operation with a held result
    rst_n = 1'b0; #1; rst_n = 1'b1; model_reset();
    drive(1'b1, 5'd10, 5'd10, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) cyc();
    res_ready = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("pre_rst_sum", res_sum, 20);
    chk("pre_rst_cnt0", cnt0, 5);
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 5'd4, 1'b1, 5'd10, 5'd5);
    res_ready = 1'b1;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_sum", res_sum, 0);
    chk("mid_rst_cnt0", cnt0, 0);
    chk("mid_rst_rdy0", req0_ready, 0);
    chk("mid_rst_rdy1", req1_ready, 0);
    rst_n = 1'b1; model_reset();

    // Contention: both valid for 4 cycles
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("arb_id", res_id, exp_ids[k]);
      chk("arb_sum", res_sum, exp_ids[k] ? 6'd15 : 6'd7);
    end
    chk("arb_cnt0", cnt0, exp_c0);
    chk("arb_cnt1", cnt1, exp_c1);

    // Backpressure: hold 9 while req1 waits, then accept with no bubble
    drive(1'b1, 5'd4, 5'd5, 1'b0, 5'd0, 5'd0);
    cyc();
    chk("bp_first", res_sum, 9);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd8);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_hold_sum", res_sum, 9);
      chk("bp_hold_rdy1", req1_ready, 0);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_rdy1", req1_ready, 1);
    cyc();
    chk("bp_new_valid", res_valid, 1);
    chk("bp_new_sum", res_sum, 15);
    chk("bp_new_id", res_id, 1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    cyc();
    chk("drain_valid", res_valid, 0);
    chk("drain_sum_hold", res_sum, 15);

    // Counter wrap on requester 1
    rst_n = 1'b0; #1; rst_n = 1'b1; model_reset();
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 5'd2);
    for (int k = 0; k < 255; k++) cyc();
    chk("wrap_255", cnt1, 255);
    cyc();
    chk("wrap_0", cnt1, 0);
    chk("wrap_cnt0", cnt0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
